// File: rtl/decoder_seq_nto2n.sv
// -----------------------------------------------------------------------------
// decoder_seq_nto2n
//
// Registered N-to-OUTS one-hot decoder with an optional auto-scan mode.
// Direct mode decodes sel every cycle. Scan mode loads a start index from sel,
// then walks the index across all outputs, holding each one for DWELL cycles.
// All outputs are registered: each response appears one clk after its inputs
// are sampled.
//
// Parameters:
//   N       select width in bits (>= 1)
//   OUTS    number of decoded outputs (2 .. 2**N)
//   DWELL   cycles each output stays active in scan mode (>= 1)
//   ACT_LOW 1 = y is active-low (inactive level is all-ones)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   en    in   block enable (0 = idle, y inactive)
//   mode  in   0 = direct decode, 1 = auto-scan
//   sel   in   direct-mode address / scan-mode start index
//   y     out  registered one-hot decode, polarity set by ACT_LOW
//   idx   out  index currently driven on y
//   wrap  out  one-cycle pulse when the scan index wraps OUTS-1 -> 0
//   err   out  one-cycle pulse when a direct-mode sel is out of range
// -----------------------------------------------------------------------------
module decoder_seq_nto2n #(
    parameter int N       = 2,
    parameter int OUTS    = 2 ** N,
    parameter int DWELL   = 4,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    output logic [OUTS-1:0] y,
    output logic [N-1:0]    idx,
    output logic            wrap,
    output logic            err
);

    localparam int               CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]     IDX_LAST = N'(OUTS - 1);
    // One extra bit so OUTS == 2**N is representable in the range compare.
    localparam logic [N:0]       OUTS_V   = (N + 1)'(OUTS);
    // Inactive output level; XOR with it applies the polarity option.
    localparam logic [OUTS-1:0]  Y_IDLE   = {OUTS{ACT_LOW}};

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [OUTS-1:0]   y_q, y_d;
    logic [N-1:0]      idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              sel_valid;
    logic              y_on;
    logic [OUTS-1:0]   y_act;

    // Explicit per-bit compare: no bit exists for indices >= OUTS.
    function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
        logic [OUTS-1:0] r;
        for (int k = 0; k < OUTS; k++) begin
            r[k] = (i == N'(k));
        end
        return r;
    endfunction

    assign sel_valid = ({1'b0, sel} < OUTS_V);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = '0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        y_on    = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else if (!mode) begin
            state_d = DIRECT;
            if (sel_valid) begin
                idx_d = sel;
                y_on  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            state_d = SCAN;
            y_on    = 1'b1;
            if (state_q != SCAN) begin
                // Entry (from IDLE or DIRECT) restarts from sel, never from
                // the old index; out-of-range starts fall back to 0.
                idx_d = sel_valid ? sel : '0;
            end else if (cnt_q == CNT_LAST) begin
                // With DWELL == 1 CNT_LAST is 0, so this branch fires every
                // cycle and the counter stays parked at 0.
                if (idx_q == IDX_LAST) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        y_act = y_on ? onehot(idx_d) : '0;
        y_d   = y_act ^ Y_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= Y_IDLE;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_decoder_seq_nto2n.sv
// -----------------------------------------------------------------------------
// tb_decoder_seq_nto2n
//
// Three decoder configurations share one set of inputs:
//   u_a : N=2, OUTS=4, DWELL=3, active-high
//   u_b : N=2, OUTS=3, DWELL=1, active-high
//   u_c : N=2, OUTS=4, DWELL=4, active-low
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_decoder_seq_nto2n;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] sel;

    logic [3:0] a_y, c_y;
    logic [2:0] b_y;
    logic [1:0] a_idx, b_idx, c_idx;
    logic       a_wrap, b_wrap, c_wrap;
    logic       a_err, b_err, c_err;

    int checks   = 0;
    int failures = 0;

    decoder_seq_nto2n #(.N(2), .OUTS(4), .DWELL(3), .ACT_LOW(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(a_y), .idx(a_idx), .wrap(a_wrap), .err(a_err)
    );

    decoder_seq_nto2n #(.N(2), .OUTS(3), .DWELL(1), .ACT_LOW(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(b_y), .idx(b_idx), .wrap(b_wrap), .err(b_err)
    );

    decoder_seq_nto2n #(.N(2), .OUTS(4), .DWELL(4), .ACT_LOW(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y(c_y), .idx(c_idx), .wrap(c_wrap), .err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bi;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        sel  = 2'd0;

        // Reset state
        #12;
        check("rst_a_y",   32'(a_y),   32'h0);
        check("rst_a_idx", 32'(a_idx), 32'h0);
        check("rst_a_wrap",32'(a_wrap),32'h0);
        check("rst_a_err", 32'(a_err), 32'h0);
        check("rst_c_y",   32'(c_y),   32'hF);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Direct decode sel=2
        en = 1'b1; mode = 1'b0; sel = 2'd2;
        step();
        check("dir_a_y",   32'(a_y),   32'b0100);
        check("dir_a_idx", 32'(a_idx), 32'd2);
        check("dir_a_err", 32'(a_err), 32'd0);
        check("dir_c_y",   32'(c_y),   32'b1011);

        // Disable: idle, idx holds
        en = 1'b0;
        step();
        check("idle_a_y",   32'(a_y),   32'b0000);
        check("idle_a_idx", 32'(a_idx), 32'd2);
        check("idle_c_y",   32'(c_y),   32'hF);

        // Active-low direct sel=1
        en = 1'b1; mode = 1'b0; sel = 2'd1;
        step();
        check("actlow_c_y", 32'(c_y), 32'b1101);

        // Scan from sel=1; sel changed after entry must be ignored
        mode = 1'b1; sel = 2'd1;
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 0) sel = 2'd3;
            check($sformatf("scan_a_y_%0d", i),    32'(a_y),    32'(4'b0001 << ((1 + i / 3) % 4)));
            check($sformatf("scan_a_wrap_%0d", i), 32'(a_wrap), 32'(i == 9));
            bi = (1 + i) % 3;
            check($sformatf("scan_b_y_%0d", i),    32'(b_y),    32'(3'b001 << bi));
            check($sformatf("scan_b_wrap_%0d", i), 32'(b_wrap), 32'(i > 0 && bi == 0));
        end
        // u_a now sits at idx=2

        // SCAN -> DIRECT sel=0
        mode = 1'b0; sel = 2'd0;
        step();
        check("sw_dir_a_y",   32'(a_y),   32'b0001);
        check("sw_dir_a_idx", 32'(a_idx), 32'd0);
        check("sw_dir_b_y",   32'(b_y),   32'b001);

        // DIRECT -> SCAN sel=3: u_a reloads at 3, u_b (OUTS=3) falls back to 0
        mode = 1'b1; sel = 2'd3;
        step();
        check("sw_scan_a_y",   32'(a_y),    32'b1000);
        check("sw_scan_b_y",   32'(b_y),    32'b001);
        check("sw_scan_b_wrap",32'(b_wrap), 32'd0);
        step();
        check("dwell1_a_y", 32'(a_y), 32'b1000);
        check("dwell1_b_y", 32'(b_y), 32'b010);
        step();
        check("dwell2_a_y",    32'(a_y),    32'b1000);
        check("dwell2_a_wrap", 32'(a_wrap), 32'd0);
        check("dwell2_b_y",    32'(b_y),    32'b100);
        step();
        check("adv_a_y",    32'(a_y),    32'b0001);
        check("adv_a_wrap", 32'(a_wrap), 32'd1);
        check("adv_b_y",    32'(b_y),    32'b001);
        check("adv_b_wrap", 32'(b_wrap), 32'd1);

        // Direct out-of-range on u_b (OUTS=3)
        mode = 1'b0; sel = 2'd2;
        step();
        check("b_dir2_y",   32'(b_y),   32'b100);
        check("b_dir2_idx", 32'(b_idx), 32'd2);
        sel = 2'd3;
        step();
        check("b_oor_y",   32'(b_y),   32'b000);
        check("b_oor_err", 32'(b_err), 32'd1);
        check("b_oor_idx", 32'(b_idx), 32'd2);
        check("a_sel3_y",  32'(a_y),   32'b1000);
        check("a_sel3_err",32'(a_err), 32'd0);
        sel = 2'd2;
        step();
        check("b_err_pulse", 32'(b_err), 32'd0);
        check("b_after_y",   32'(b_y),   32'b100);

        // Async reset mid-scan
        mode = 1'b1; sel = 2'd0;
        for (int i = 0; i < 4; i++) step();
        check("prerst_a_y", 32'(a_y), 32'b0010);
        #3;
        rst = 1'b1;
        #1;
        check("arst_a_y",    32'(a_y),    32'h0);
        check("arst_a_idx",  32'(a_idx),  32'h0);
        check("arst_a_wrap", 32'(a_wrap), 32'h0);
        check("arst_c_y",    32'(c_y),    32'hF);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_a_y",    32'(a_y),    32'b0001);
        check("post_a_wrap", 32'(a_wrap), 32'd0);
        check("post_a_err",  32'(a_err),  32'd0);
        check("post_b_wrap", 32'(b_wrap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
